sbp_lookup_inject: RTL and testbench

//  Head of the lookup pipeline; directly feeds the first sbp lookup stage.

---
 rtl/sbp_pkg.sv | 53 +++++
 rtl/sbp_credit_counter.sv | 58 +++++
 rtl/sbp_lookup_inject.sv | 172 +++++++++++++++++
 tb/tb_sbp_lookup_inject.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sbp_pkg.sv
// -----------------------------------------------------------------------------
// sbp_pkg
// Shared definitions for the sbp lookup pipeline.
//   - Default field widths (stage id, location, bit position).
//   - Result-word width derivation: a result word holds a left and a right
//     child pointer (stage id + location each), padded up to a multiple of
//     the padding granularity.
//   - The pipeline slot struct carried from the injector into the first stage.
//   - Grant encoding used by the injector arbiter.
// No ports (package).
// -----------------------------------------------------------------------------
package sbp_pkg;

    localparam int SBP_STAGE_ID_BITS = 6;
    localparam int SBP_LOCATION_BITS = 11;
    localparam int SBP_PAD_BITS      = 4;

    // Bit position covers 0..32 inclusive, so 6 bits.
    localparam int BIT_POS_BITS      = 6;

    // Rounds w up to the next multiple of g.
    function automatic int sbp_pad_up(input int w, input int g);
        return ((w + g - 1) / g) * g;
    endfunction

    // Width of one result word for a given stage-id/location geometry.
    function automatic int sbp_result_bits(input int stage_bits, input int loc_bits,
                                           input int pad_bits);
        return sbp_pad_up(2 * (stage_bits + loc_bits), pad_bits);
    endfunction

    localparam int CHILD_PTR_BITS    = SBP_STAGE_ID_BITS + SBP_LOCATION_BITS;
    localparam int CHILD_LR_BITS     = 2 * CHILD_PTR_BITS;
    localparam int SBP_RESULT_BITS   = sbp_pad_up(CHILD_LR_BITS, SBP_PAD_BITS);

    // One pipeline slot as presented to the first lookup stage.
    typedef struct packed {
        logic                         update;
        logic                         lookup_valid;
        logic [31:0]                  ip_addr;
        logic [BIT_POS_BITS-1:0]      bit_pos;
        logic [SBP_STAGE_ID_BITS-1:0] stage_id;
        logic [SBP_LOCATION_BITS-1:0] location;
        logic [SBP_RESULT_BITS-1:0]   result;
    } sbp_slot_t;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_UPD  = 2'd1,
        GRANT_LKP  = 2'd2
    } sbp_grant_e;

endpackage

// File: rtl/sbp_credit_counter.sv
// -----------------------------------------------------------------------------
// sbp_credit_counter
// Tracks how many lookups may still be injected before the result sink fills.
// Starts full (CREDITS) after reset. A take consumes one credit, a return
// gives one back; both in the same cycle cancel. A return while already full
// is dropped and latches the sticky error flag until reset.
// Ports:
//   clk       in   clock
//   rst       in   synchronous, active-high reset
//   take_i    in   one lookup injected this cycle (only asserted when avail_o)
//   return_i  in   sink freed one slot
//   avail_o   out  at least one credit available
//   err_o     out  sticky: return seen while counter was full
// -----------------------------------------------------------------------------
module sbp_credit_counter #(
    parameter int CREDITS = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic take_i,
    input  logic return_i,
    output logic avail_o,
    output logic err_o
);

    localparam int CNT_W = $clog2(CREDITS + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (take_i && !return_i) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else if (return_i && !take_i) begin
            if (cnt_q == CNT_W'(CREDITS)) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= CNT_W'(CREDITS);
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign avail_o = (cnt_q != '0);
    assign err_o   = err_q;

endmodule

// File: rtl/sbp_lookup_inject.sv
// -----------------------------------------------------------------------------
// sbp_lookup_inject
// Head of the lookup pipeline. Each cycle it fills one slot for the first sbp
// lookup stage with either a table update, a lookup (starting at the trie
// root), or a bubble. Lookups are limited by credits from the result sink;
// updates win arbitration by default, but after MAX_UPD_BURST consecutive
// update grants with a lookup waiting the lookup is forced through.
// Optional feature macro: SBP_INJECT_STATS_EN builds 32-bit grant counters;
// without it lkp_cnt_o/upd_cnt_o are tied to 0.
// Ports:
//   clk, rst                synchronous active-high reset
//   lkp_valid_i/ready_o     lookup request handshake, lkp_ip_addr_i address
//   upd_valid_i/ready_o     update request handshake with prefix, length,
//                           target stage/location and result word
//   credit_return_i         sink freed one lookup slot
//   update_o, lookup_valid_o, ip_addr_o, bit_pos_o, stage_id_o, location_o,
//   result_o                registered slot towards the first stage
//   credit_err_o            sticky credit overflow flag
//   lkp_cnt_o, upd_cnt_o    grant counters (feature macro)
// -----------------------------------------------------------------------------
module sbp_lookup_inject
    import sbp_pkg::*;
#(
    parameter  int STAGE_ID_BITS = SBP_STAGE_ID_BITS,
    parameter  int LOCATION_BITS = SBP_LOCATION_BITS,
    parameter  int PAD_BITS      = SBP_PAD_BITS,
    parameter  int ROOT_STAGE_ID = 1,
    parameter  int ROOT_LOCATION = 0,
    parameter  int CREDITS       = 16,
    parameter  int MAX_UPD_BURST = 4,
    localparam int RESULT_BITS   = sbp_result_bits(STAGE_ID_BITS, LOCATION_BITS, PAD_BITS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     lkp_valid_i,
    output logic                     lkp_ready_o,
    input  logic [31:0]              lkp_ip_addr_i,
    input  logic                     upd_valid_i,
    output logic                     upd_ready_o,
    input  logic [31:0]              upd_prefix_i,
    input  logic [5:0]               upd_prefix_len_i,
    input  logic [STAGE_ID_BITS-1:0] upd_stage_id_i,
    input  logic [LOCATION_BITS-1:0] upd_location_i,
    input  logic [RESULT_BITS-1:0]   upd_result_i,
    input  logic                     credit_return_i,
    output logic                     update_o,
    output logic                     lookup_valid_o,
    output logic [31:0]              ip_addr_o,
    output logic [5:0]               bit_pos_o,
    output logic [STAGE_ID_BITS-1:0] stage_id_o,
    output logic [LOCATION_BITS-1:0] location_o,
    output logic [RESULT_BITS-1:0]   result_o,
    output logic                     credit_err_o,
    output logic [31:0]              lkp_cnt_o,
    output logic [31:0]              upd_cnt_o
);

    localparam int BURST_W = $clog2(MAX_UPD_BURST + 1);

    logic               lkp_ok;
    logic               force_lkp;
    sbp_grant_e         grant;
    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
    sbp_slot_t          slot_q, slot_d;

    sbp_credit_counter #(
        .CREDITS (CREDITS)
    ) u_credit (
        .clk      (clk),
        .rst      (rst),
        .take_i   (grant == GRANT_LKP),
        .return_i (credit_return_i),
        .avail_o  (lkp_ok),
        .err_o    (credit_err_o)
    );

    // Arbitration: updates are preferred unless the burst limit has been hit
    // with a grantable lookup waiting. The two readies are mutually exclusive
    // whenever both requests are valid, so at most one grant per cycle.
    always_comb begin
        force_lkp   = lkp_valid_i && lkp_ok && (burst_cnt_q == BURST_W'(MAX_UPD_BURST));
        upd_ready_o = !force_lkp;
        lkp_ready_o = lkp_ok && (!upd_valid_i || force_lkp);

        grant = GRANT_NONE;
        if (lkp_valid_i && lkp_ready_o) begin
            grant = GRANT_LKP;
        end else if (upd_valid_i && upd_ready_o) begin
            grant = GRANT_UPD;
        end
    end

    // Burst counter only advances while a lookup could have gone instead;
    // any cycle without a grantable lookup waiting restarts the window.
    always_comb begin
        burst_cnt_d = burst_cnt_q;
        if (grant == GRANT_LKP || !(lkp_valid_i && lkp_ok)) begin
            burst_cnt_d = '0;
        end else if (grant == GRANT_UPD && burst_cnt_q != BURST_W'(MAX_UPD_BURST)) begin
            burst_cnt_d = burst_cnt_q + BURST_W'(1);
        end
    end

    // Slot contents. A bubble is all zeros; stage id 0 addresses no stage.
    always_comb begin
        slot_d = '0;
        case (grant)
            GRANT_UPD: begin
                slot_d.update   = 1'b1;
                slot_d.ip_addr  = upd_prefix_i;
                slot_d.bit_pos  = upd_prefix_len_i;
                slot_d.stage_id = upd_stage_id_i;
                slot_d.location = upd_location_i;
                slot_d.result   = upd_result_i;
            end
            GRANT_LKP: begin
                slot_d.lookup_valid = 1'b1;
                slot_d.ip_addr      = lkp_ip_addr_i;
                slot_d.stage_id     = STAGE_ID_BITS'(ROOT_STAGE_ID);
                slot_d.location     = LOCATION_BITS'(ROOT_LOCATION);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q      <= '0;
            burst_cnt_q <= '0;
        end else begin
            slot_q      <= slot_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign update_o       = slot_q.update;
    assign lookup_valid_o = slot_q.lookup_valid;
    assign ip_addr_o      = slot_q.ip_addr;
    assign bit_pos_o      = slot_q.bit_pos;
    assign stage_id_o     = slot_q.stage_id;
    assign location_o     = slot_q.location;
    assign result_o       = slot_q.result;

`ifdef SBP_INJECT_STATS_EN
    logic [31:0] lkp_cnt_q, lkp_cnt_d;
    logic [31:0] upd_cnt_q, upd_cnt_d;

    always_comb begin
        lkp_cnt_d = lkp_cnt_q;
        upd_cnt_d = upd_cnt_q;
        if (grant == GRANT_LKP) lkp_cnt_d = lkp_cnt_q + 32'd1;
        if (grant == GRANT_UPD) upd_cnt_d = upd_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lkp_cnt_q <= '0;
            upd_cnt_q <= '0;
        end else begin
            lkp_cnt_q <= lkp_cnt_d;
            upd_cnt_q <= upd_cnt_d;
        end
    end

    assign lkp_cnt_o = lkp_cnt_q;
    assign upd_cnt_o = upd_cnt_q;
`else
    assign lkp_cnt_o = '0;
    assign upd_cnt_o = '0;
`endif

endmodule

// File: tb/tb_sbp_lookup_inject.sv
// -----------------------------------------------------------------------------
// tb_sbp_lookup_inject
// Scoreboard bench for sbp_lookup_inject: a monitor records the slot each
// handshake (or bubble) should produce and checks it one cycle later; the
// scenario tasks check readies, arbitration order, credit limits and the
// sticky error flag inline.
// -----------------------------------------------------------------------------
module tb_sbp_lookup_inject;
    import sbp_pkg::*;

    localparam int RB = SBP_RESULT_BITS;

    logic                         clk;
    logic                         rst;
    logic                         lkp_valid_i;
    logic                         lkp_ready_o;
    logic [31:0]                  lkp_ip_addr_i;
    logic                         upd_valid_i;
    logic                         upd_ready_o;
    logic [31:0]                  upd_prefix_i;
    logic [5:0]                   upd_prefix_len_i;
    logic [SBP_STAGE_ID_BITS-1:0] upd_stage_id_i;
    logic [SBP_LOCATION_BITS-1:0] upd_location_i;
    logic [RB-1:0]                upd_result_i;
    logic                         credit_return_i;
    logic                         update_o;
    logic                         lookup_valid_o;
    logic [31:0]                  ip_addr_o;
    logic [5:0]                   bit_pos_o;
    logic [SBP_STAGE_ID_BITS-1:0] stage_id_o;
    logic [SBP_LOCATION_BITS-1:0] location_o;
    logic [RB-1:0]                result_o;
    logic                         credit_err_o;
    logic [31:0]                  lkp_cnt_o;
    logic [31:0]                  upd_cnt_o;

    sbp_lookup_inject dut (
        .clk              (clk),
        .rst              (rst),
        .lkp_valid_i      (lkp_valid_i),
        .lkp_ready_o      (lkp_ready_o),
        .lkp_ip_addr_i    (lkp_ip_addr_i),
        .upd_valid_i      (upd_valid_i),
        .upd_ready_o      (upd_ready_o),
        .upd_prefix_i     (upd_prefix_i),
        .upd_prefix_len_i (upd_prefix_len_i),
        .upd_stage_id_i   (upd_stage_id_i),
        .upd_location_i   (upd_location_i),
        .upd_result_i     (upd_result_i),
        .credit_return_i  (credit_return_i),
        .update_o         (update_o),
        .lookup_valid_o   (lookup_valid_o),
        .ip_addr_o        (ip_addr_o),
        .bit_pos_o        (bit_pos_o),
        .stage_id_o       (stage_id_o),
        .location_o       (location_o),
        .result_o         (result_o),
        .credit_err_o     (credit_err_o),
        .lkp_cnt_o        (lkp_cnt_o),
        .upd_cnt_o        (upd_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int lkp_seen = 0;
    int upd_seen = 0;

    sbp_slot_t exp_q[$];
    sbp_slot_t mon_exp;
    sbp_slot_t mon_got;
    sbp_slot_t mon_pop;

    // Scoreboard monitor: at the falling edge, inputs and readies are stable,
    // so the slot the next rising edge must produce is known.
    initial begin
        forever begin
            @(negedge clk);
            mon_exp = '0;
            if (rst) begin
                lkp_seen = 0;
                upd_seen = 0;
            end else begin
                n_cmp++;
                if (lkp_valid_i && lkp_ready_o && upd_valid_i && upd_ready_o) begin
                    n_bad++;
                    $display("FAIL dual_grant: both lookup and update granted at %0t, required at most one", $time);
                end
                if (lkp_valid_i && lkp_ready_o) begin
                    mon_exp.lookup_valid = 1'b1;
                    mon_exp.ip_addr      = lkp_ip_addr_i;
                    mon_exp.stage_id     = 6'd1;
                    mon_exp.location     = 11'd0;
                    lkp_seen++;
                end else if (upd_valid_i && upd_ready_o) begin
                    mon_exp.update   = 1'b1;
                    mon_exp.ip_addr  = upd_prefix_i;
                    mon_exp.bit_pos  = upd_prefix_len_i;
                    mon_exp.stage_id = upd_stage_id_i;
                    mon_exp.location = upd_location_i;
                    mon_exp.result   = upd_result_i;
                    upd_seen++;
                end
            end
            exp_q.push_back(mon_exp);
            @(posedge clk);
            #1;
            mon_got = {update_o, lookup_valid_o, ip_addr_o, bit_pos_o, stage_id_o, location_o, result_o};
            mon_pop = exp_q.pop_front();
            n_cmp++;
            if (mon_got !== mon_pop) begin
                n_bad++;
                $display("FAIL slot at %0t: got %h required %h", $time, mon_got, mon_pop);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        lkp_valid_i      = 1'b0;
        lkp_ip_addr_i    = '0;
        upd_valid_i      = 1'b0;
        upd_prefix_i     = '0;
        upd_prefix_len_i = '0;
        upd_stage_id_i   = '0;
        upd_location_i   = '0;
        upd_result_i     = '0;
        credit_return_i  = 1'b0;
    endtask

    task automatic return_credits(input int n);
        credit_return_i = 1'b1;
        repeat (n) cyc();
        credit_return_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        repeat (3) cyc();
        n_cmp++;
        if ({update_o, lookup_valid_o, ip_addr_o, bit_pos_o, stage_id_o, location_o, result_o} !== '0) begin
            n_bad++;
            $display("FAIL reset_slot: got %h required 0",
                     {update_o, lookup_valid_o, ip_addr_o, bit_pos_o, stage_id_o, location_o, result_o});
        end
        n_cmp++;
        if ({credit_err_o, lkp_cnt_o, upd_cnt_o} !== '0) begin
            n_bad++;
            $display("FAIL reset_flags: err %b lkp_cnt %0d upd_cnt %0d required all 0",
                     credit_err_o, lkp_cnt_o, upd_cnt_o);
        end
        rst = 1'b0;
        cyc();
        n_cmp++;
        if (lkp_ready_o !== 1'b1 || upd_ready_o !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready: lkp_ready %b upd_ready %b required 1 1", lkp_ready_o, upd_ready_o);
        end
        repeat (3) cyc();
    endtask

    task automatic test_lookup();
        lkp_valid_i   = 1'b1;
        lkp_ip_addr_i = 32'hC0A8_0001;
        #1;
        n_cmp++;
        if (lkp_ready_o !== 1'b1) begin
            n_bad++;
            $display("FAIL lookup_ready: got %b required 1", lkp_ready_o);
        end
        cyc();
        drive_idle();
        n_cmp++;
        if (lookup_valid_o !== 1'b1 || update_o !== 1'b0 || stage_id_o !== 6'd1 ||
            location_o !== 11'd0 || bit_pos_o !== 6'd0 || ip_addr_o !== 32'hC0A8_0001) begin
            n_bad++;
            $display("FAIL lookup_slot: lv %b upd %b stage %0d loc %0d bit %0d ip %h required 1 0 1 0 0 c0a80001",
                     lookup_valid_o, update_o, stage_id_o, location_o, bit_pos_o, ip_addr_o);
        end
        return_credits(1);
        cyc();
    endtask

    task automatic test_update();
        upd_valid_i      = 1'b1;
        upd_prefix_i     = 32'h0A00_0000;
        upd_prefix_len_i = 6'd8;
        upd_stage_id_i   = 6'd3;
        upd_location_i   = 11'd5;
        upd_result_i     = 36'h9_1234_5678;
        #1;
        n_cmp++;
        if (upd_ready_o !== 1'b1) begin
            n_bad++;
            $display("FAIL update_ready: got %b required 1", upd_ready_o);
        end
        cyc();
        drive_idle();
        n_cmp++;
        if (update_o !== 1'b1 || lookup_valid_o !== 1'b0 || ip_addr_o !== 32'h0A00_0000 ||
            bit_pos_o !== 6'd8 || stage_id_o !== 6'd3 || location_o !== 11'd5 ||
            result_o !== 36'h9_1234_5678) begin
            n_bad++;
            $display("FAIL update_slot: upd %b lv %b ip %h bit %0d stage %0d loc %0d res %h",
                     update_o, lookup_valid_o, ip_addr_o, bit_pos_o, stage_id_o, location_o, result_o);
        end
        cyc();
    endtask

    task automatic test_burst();
        logic g_lkp;
        logic want_lkp;
        lkp_valid_i      = 1'b1;
        upd_valid_i      = 1'b1;
        upd_prefix_len_i = 6'd16;
        upd_stage_id_i   = 6'd2;
        for (int i = 0; i < 15; i++) begin
            lkp_ip_addr_i  = 32'h1000_0000 + i;
            upd_prefix_i   = 32'hAC10_0000 + (i << 8);
            upd_location_i = 11'(i);
            #1;
            g_lkp    = lkp_ready_o;
            want_lkp = ((i % 5) == 4);
            n_cmp++;
            if (g_lkp !== want_lkp || upd_ready_o !== !want_lkp) begin
                n_bad++;
                $display("FAIL burst_order[%0d]: lkp_ready %b upd_ready %b required %b %b",
                         i, g_lkp, upd_ready_o, want_lkp, !want_lkp);
            end
            cyc();
        end
        drive_idle();
        return_credits(3);
        cyc();
    endtask

    task automatic test_credit_limit();
        int granted;
        granted = 0;
        lkp_valid_i = 1'b1;
        for (int i = 0; i < 17; i++) begin
            lkp_ip_addr_i = 32'h2000_0000 + i;
            #1;
            if (lkp_ready_o === 1'b1) granted++;
            cyc();
        end
        n_cmp++;
        if (granted !== 16) begin
            n_bad++;
            $display("FAIL credit_grants: got %0d required 16", granted);
        end
        upd_valid_i      = 1'b1;
        upd_prefix_i     = 32'hC0A8_0000;
        upd_prefix_len_i = 6'd24;
        upd_stage_id_i   = 6'd7;
        upd_location_i   = 11'd100;
        #1;
        n_cmp++;
        if (lkp_ready_o !== 1'b0 || upd_ready_o !== 1'b1) begin
            n_bad++;
            $display("FAIL credit_empty_ready: lkp_ready %b upd_ready %b required 0 1", lkp_ready_o, upd_ready_o);
        end
        cyc();
        upd_valid_i     = 1'b0;
        credit_return_i = 1'b1;
        #1;
        n_cmp++;
        if (lkp_ready_o !== 1'b0) begin
            n_bad++;
            $display("FAIL credit_return_same_cycle: lkp_ready %b required 0", lkp_ready_o);
        end
        cyc();
        credit_return_i = 1'b0;
        #1;
        n_cmp++;
        if (lkp_ready_o !== 1'b1) begin
            n_bad++;
            $display("FAIL credit_17th: lkp_ready %b required 1", lkp_ready_o);
        end
        cyc();
        lkp_valid_i = 1'b0;
        #1;
        n_cmp++;
        if (lkp_ready_o !== 1'b0) begin
            n_bad++;
            $display("FAIL credit_empty_again: lkp_ready %b required 0", lkp_ready_o);
        end
        drive_idle();
        return_credits(16);
        cyc();
        n_cmp++;
        if (credit_err_o !== 1'b0 || lkp_ready_o !== 1'b1) begin
            n_bad++;
            $display("FAIL credit_refill: err %b lkp_ready %b required 0 1", credit_err_o, lkp_ready_o);
        end
    endtask

    task automatic test_credit_err();
        int granted;
        granted = 0;
        return_credits(1);
        #1;
        n_cmp++;
        if (credit_err_o !== 1'b1) begin
            n_bad++;
            $display("FAIL credit_err_set: got %b required 1", credit_err_o);
        end
        repeat (3) cyc();
        n_cmp++;
        if (credit_err_o !== 1'b1) begin
            n_bad++;
            $display("FAIL credit_err_sticky: got %b required 1", credit_err_o);
        end
        lkp_valid_i     = 1'b1;
        lkp_ip_addr_i   = 32'h3000_0000;
        credit_return_i = 1'b1;
        cyc();
        credit_return_i = 1'b0;
        for (int i = 0; i < 17; i++) begin
            lkp_ip_addr_i = 32'h3000_0001 + i;
            #1;
            if (lkp_ready_o === 1'b1) granted++;
            cyc();
        end
        n_cmp++;
        if (granted !== 16) begin
            n_bad++;
            $display("FAIL credit_grant_and_return: later grants %0d required 16", granted);
        end
        drive_idle();
        cyc();
    endtask

    task automatic test_stats();
        int want_l;
        int want_u;
`ifdef SBP_INJECT_STATS_EN
        want_l = lkp_seen;
        want_u = upd_seen;
`else
        want_l = 0;
        want_u = 0;
`endif
        n_cmp++;
        if (lkp_cnt_o !== 32'(want_l) || upd_cnt_o !== 32'(want_u)) begin
            n_bad++;
            $display("FAIL stats: lkp_cnt %0d upd_cnt %0d required %0d %0d", lkp_cnt_o, upd_cnt_o, want_l, want_u);
        end
    endtask

    task automatic test_reset_mid();
        int granted;
        granted = 0;
        lkp_valid_i = 1'b1;
        upd_valid_i = 1'b1;
        rst         = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        drive_idle();
        #1;
        n_cmp++;
        if (credit_err_o !== 1'b0 || lkp_ready_o !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid: err %b lkp_ready %b required 0 1", credit_err_o, lkp_ready_o);
        end
        lkp_valid_i = 1'b1;
        for (int i = 0; i < 17; i++) begin
            lkp_ip_addr_i = 32'h4000_0000 + i;
            #1;
            if (lkp_ready_o === 1'b1) granted++;
            cyc();
        end
        n_cmp++;
        if (granted !== 16) begin
            n_bad++;
            $display("FAIL reset_mid_credits: got %0d required 16", granted);
        end
        drive_idle();
        cyc();
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        test_reset();
        test_lookup();
        test_update();
        test_burst();
        test_credit_limit();
        test_stats();
        test_credit_err();
        test_reset_mid();
        test_stats();
        repeat (2) cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
